// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared types and helpers for the conv weight ROM fetch path: FSM state
// encoding, default ROM geometry and the clogb2 width helper.
package rom_fetch_ctrl_pkg;

  localparam int unsigned DEF_RAM_WIDTH = 32;
  localparam int unsigned DEF_RAM_DEPTH = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Number of bits needed to represent value (0 -> 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_fetch_fifo.sv
// fetch_fifo: synchronous FIFO (DEPTH power of two) with occupancy count,
// buffering ROM words plus their last flag ahead of the output stream.
module fetch_fifo
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [clogb2(DEPTH)-1:0]   count
);

  localparam int unsigned PTR_W = clogb2(DEPTH - 1);
  localparam int unsigned CNT_W = clogb2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: issues a contiguous ROM read run and streams the words out
// as valid/ready. Optional ROM_FETCH_REPEAT_EN adds rep_cnt replay passes.
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [clogb2(RAM_DEPTH-1)-1:0]    base_addr,
  input  logic [clogb2(RAM_DEPTH-1):0]      length,
`ifdef ROM_FETCH_REPEAT_EN
  input  logic [7:0]                        rep_cnt,
`endif
  output logic                              busy,
  output logic                              done,
  output logic [clogb2(RAM_DEPTH-1)-1:0]    rom_addr,
  output logic                              rom_en,
  input  logic [RAM_WIDTH-1:0]              rom_dout,
  output logic                              m_valid,
  output logic [RAM_WIDTH-1:0]              m_data,
  output logic                              m_last,
  input  logic                              m_ready
);

  localparam int unsigned ADDR_W = clogb2(RAM_DEPTH - 1);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = clogb2(FIFO_DEPTH);

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic               rd_pending;
  logic               rd_last;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;
  logic               fifo_empty;
  logic [RAM_WIDTH:0] head;
  logic               last_issue;
  logic [ADDR_W-1:0]  next_addr;

`ifdef ROM_FETCH_REPEAT_EN
  logic [7:0]         passes_left;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   len_q;
  assign last_issue = (remaining == LEN_W'(1)) && (passes_left == '0);
`else
  assign last_issue = (remaining == LEN_W'(1));
`endif

  // Reads in flight count against capacity so every issued word has a slot.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
  assign rom_en    = (state == ST_FETCH) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign next_addr = (rom_addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : rom_addr + ADDR_W'(1);

  assign busy    = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign m_valid = !fifo_empty;
  assign m_data  = head[RAM_WIDTH-1:0];
  assign m_last  = !fifo_empty && head[RAM_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      rd_last    <= 1'b0;
`ifdef ROM_FETCH_REPEAT_EN
      passes_left <= '0;
      base_q      <= '0;
      len_q       <= '0;
`endif
    end else begin
      rd_pending <= rom_en;
      rd_last    <= rom_en && last_issue;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr  <= base_addr;
            remaining <= length;
`ifdef ROM_FETCH_REPEAT_EN
            passes_left <= rep_cnt;
            base_q      <= base_addr;
            len_q       <= length;
`endif
            state <= (length == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rom_en) begin
            if (remaining == LEN_W'(1)) begin
`ifdef ROM_FETCH_REPEAT_EN
              // Reload the run without a gap while passes remain.
              if (passes_left != '0) begin
                passes_left <= passes_left - 8'd1;
                rom_addr    <= base_q;
                remaining   <= len_q;
              end else begin
                state <= ST_DRAIN;
              end
`else
              state <= ST_DRAIN;
`endif
            end else begin
              rom_addr  <= next_addr;
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (m_valid && m_ready && m_last) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pending),
    .din   ({rd_last, rom_dout}),
    .pop   (m_valid && m_ready),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
